// File: rtl/alu_arb_pkg.sv
// Shared types and helpers for the round-robin ALU arbiter: FSM state encoding,
// opcode map of the shared ALU, and the round-robin winner search.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int NUM_OPS = 12;
    localparam int MAX_REQ = 8;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NAND  = 4'b0101;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0111;
    localparam logic [3:0] OP_INC   = 4'b1000;
    localparam logic [3:0] OP_DEC   = 4'b1001;
    localparam logic [3:0] OP_PASSA = 4'b1010;
    localparam logic [3:0] OP_PASSB = 4'b1011;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } rr_pick_t;

    // Id width never drops below one bit, even for a single requester.
    function automatic int calc_idw(input int n_req);
        return (n_req <= 2) ? 1 : $clog2(n_req);
    endfunction

    // First valid requester found when searching ptr, ptr+1, ... modulo n_req.
    function automatic rr_pick_t rr_select(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 n_req);
        rr_pick_t   pick;
        logic [2:0] idx_v;
        pick.found = 1'b0;
        pick.idx   = 3'd0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n_req) begin
                idx_v = 3'((int'(ptr) + k) % n_req);
                if (!pick.found && valid[idx_v]) begin
                    pick.found = 1'b1;
                    pick.idx   = idx_v;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/alu01.sv
// Shared combinational ALU. Result is one bit wider than the operands; the
// extra MSB carries the carry/borrow (or the shifted-out bit for shifts).
module alu01
    import alu_arb_pkg::*;
#(
    parameter int W   = 8,
    parameter int OPW = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [OPW-1:0] op,
    output logic [W:0]     result
);

    // Opcode decode; unknown opcodes yield zero.
    always_comb begin
        result = {(W+1){1'b0}};
        case (op)
            OPW'(OP_ADD):   result = {1'b0, a} + {1'b0, b};
            OPW'(OP_SUB):   result = {1'b0, a} - {1'b0, b};
            OPW'(OP_AND):   result = {1'b0, a & b};
            OPW'(OP_OR):    result = {1'b0, a | b};
            OPW'(OP_XOR):   result = {1'b0, a ^ b};
            OPW'(OP_NAND):  result = {1'b0, ~(a & b)};
            OPW'(OP_SHL):   result = {a, 1'b0};
            OPW'(OP_SHR):   result = {a[0], 1'b0, a[W-1:1]};
            OPW'(OP_INC):   result = {1'b0, a} + (W+1)'(1);
            OPW'(OP_DEC):   result = {1'b0, a} - (W+1)'(1);
            OPW'(OP_PASSA): result = {1'b0, a};
            OPW'(OP_PASSB): result = {1'b0, b};
            default:        result = {(W+1){1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Time-shares one alu01 between N_REQ requesters. A round-robin grant latches
// the winner's operands, the ALU result is registered one cycle later, and the
// response is held on a valid/ready channel tagged with the requester id.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int W       = 8,
    parameter int OPW     = 4,
    parameter int NUM_OPS = alu_arb_pkg::NUM_OPS,
    parameter int IDW     = calc_idw(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    input  logic [N_REQ*OPW-1:0] req_op,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [W:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    state_t           state_r;
    logic [IDW-1:0]   rr_ptr_r;
    logic [W-1:0]     opa_r;
    logic [W-1:0]     opb_r;
    logic [OPW-1:0]   opc_r;
    logic [IDW-1:0]   id_r;
    logic             rsp_valid_r;
    logic [IDW-1:0]   rsp_id_r;
    logic [W:0]       rsp_data_r;
    logic             rsp_err_r;
    logic             busy_r;

    logic [W:0]       alu_out_s;
    logic             illegal_s;
    logic             arb_en_s;
    logic [IDW-1:0]   ptr_next_s;
    logic [IDW-1:0]   ptr_eff_s;
    rr_pick_t         pick_s;
    logic             grant_s;
    logic [IDW-1:0]   win_id_s;
    logic [W-1:0]     win_a_s;
    logic [W-1:0]     win_b_s;
    logic [OPW-1:0]   win_op_s;
    logic [N_REQ-1:0] ready_s;

    alu01 #(
        .W   (W),
        .OPW (OPW)
    ) u_alu (
        .a      (opa_r),
        .b      (opb_r),
        .op     (opc_r),
        .result (alu_out_s)
    );

    assign illegal_s = (int'(opc_r) >= NUM_OPS);

    // Pointer value after the current response is consumed: owner id + 1, wrapping.
    always_comb begin
        if (id_r == IDW'(N_REQ - 1)) begin
            ptr_next_s = IDW'(0);
        end else begin
            ptr_next_s = id_r + IDW'(1);
        end
    end

    // Arbitration window: idle, or the response handshake cycle (using the
    // pointer that handshake is about to write, so the next grant is fair).
    always_comb begin
        if (rst) begin
            arb_en_s  = 1'b0;
            ptr_eff_s = rr_ptr_r;
        end else if (state_r == ST_IDLE) begin
            arb_en_s  = 1'b1;
            ptr_eff_s = rr_ptr_r;
        end else if (state_r == ST_RESP) begin
            arb_en_s  = rsp_ready;
            ptr_eff_s = ptr_next_s;
        end else begin
            arb_en_s  = 1'b0;
            ptr_eff_s = rr_ptr_r;
        end
    end

    assign pick_s   = rr_select(MAX_REQ'(req_valid), 3'(ptr_eff_s), N_REQ);
    assign grant_s  = arb_en_s & pick_s.found;
    assign win_id_s = IDW'(pick_s.idx);
    assign win_a_s  = req_a[win_id_s*W +: W];
    assign win_b_s  = req_b[win_id_s*W +: W];
    assign win_op_s = req_op[win_id_s*OPW +: OPW];

    // One-hot accept toward the winning requester, only in the grant cycle.
    always_comb begin
        ready_s = {N_REQ{1'b0}};
        if (grant_s) begin
            ready_s = N_REQ'(1) << win_id_s;
        end else begin
            ready_s = {N_REQ{1'b0}};
        end
    end

    // Capture the winner's operands and id whenever a grant is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_r <= {W{1'b0}};
            opb_r <= {W{1'b0}};
            opc_r <= {OPW{1'b0}};
            id_r  <= {IDW{1'b0}};
        end else if (grant_s) begin
            opa_r <= win_a_s;
            opb_r <= win_b_s;
            opc_r <= win_op_s;
            id_r  <= win_id_s;
        end
    end

    // Control FSM with registered response channel, pointer and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {IDW{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {IDW{1'b0}};
            rsp_data_r  <= {(W+1){1'b0}};
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        state_r <= ST_EXEC;
                        busy_r  <= 1'b1;
                    end
                end
                ST_EXEC: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= id_r;
                    if (illegal_s) begin
                        rsp_data_r <= {(W+1){1'b0}};
                        rsp_err_r  <= 1'b1;
                    end else begin
                        rsp_data_r <= alu_out_s;
                        rsp_err_r  <= 1'b0;
                    end
                    state_r <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        rr_ptr_r    <= ptr_next_s;
                        if (grant_s) begin
                            state_r <= ST_EXEC;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed scenarios plus a randomized run against
// a transaction-level model (one outstanding op, round-robin pointer, ALU math).
module tb_alu_rr_arbiter;

    localparam int N   = 2;
    localparam int W   = 8;
    localparam int OPW = 4;
    localparam int IDW = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N*OPW-1:0] req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [W:0]       rsp_data;
    logic             rsp_err;
    logic             busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(.N_REQ(N), .W(W), .OPW(OPW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // ALU reference written as plain integer arithmetic, masked to 9 bits.
    function automatic logic [8:0] golden(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = (~(a & b)) & 255;
            6:       r = a * 2;
            7:       r = (a % 2) * 256 + a / 2;
            8:       r = a + 1;
            9:       r = a - 1;
            10:      r = a;
            11:      r = b;
            default: r = 0;
        endcase
        return 9'(r & 511);
    endfunction

    // Requester served next: first valid one at or after p, wrapping.
    function automatic int pick_m(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [7:0] a,
                           input logic [7:0] b, input logic [3:0] op);
        req_valid[i]         = v;
        req_a[i*W +: W]      = a;
        req_b[i*W +: W]      = b;
        req_op[i*OPW +: OPW] = op;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        total_cnt++; if (req_ready !== 2'b00) $display("FAIL reset_ready got=%b exp=00", req_ready); else pass_cnt++;
        total_cnt++; if ({rsp_valid, busy, rsp_err} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {rsp_valid, busy, rsp_err}); else pass_cnt++;
        total_cnt++; if ({rsp_id, rsp_data} !== 10'h000) $display("FAIL reset_data got=%h exp=000", {rsp_id, rsp_data}); else pass_cnt++;
        req_valid = 2'b00;
        rst       = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total_cnt++; if ({busy, rsp_valid, req_ready} !== 4'b0000) $display("FAIL idle_quiet cyc=%0d got=%b exp=0000", c, {busy, rsp_valid, req_ready}); else pass_cnt++;
        end
    endtask

    task automatic test_single();
        logic [8:0] exp_d;
        exp_d = golden(8'h6B, 8'hAA, 0);
        @(negedge clk);
        set_req(0, 1'b1, 8'h6B, 8'hAA, 4'h0);
        rsp_ready = 1'b0;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL single_grant got=%b exp=01", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
        total_cnt++; if ({rsp_valid, busy} !== 2'b01) $display("FAIL single_exec got=%b exp=01", {rsp_valid, busy}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (rsp_valid !== 1'b1) $display("FAIL single_latency got=%b exp=1", rsp_valid); else pass_cnt++;
        total_cnt++; if ({rsp_id, rsp_err} !== 2'b00) $display("FAIL single_id_err got=%b exp=00", {rsp_id, rsp_err}); else pass_cnt++;
        total_cnt++; if (rsp_data !== exp_d) $display("FAIL single_data got=%h exp=%h", rsp_data, exp_d); else pass_cnt++;
        req_valid = 2'b01;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++; if (req_ready !== 2'b00) $display("FAIL hold_no_grant cyc=%0d got=%b exp=00", c, req_ready); else pass_cnt++;
            @(negedge clk);
            total_cnt++; if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b100, exp_d}) $display("FAIL single_hold cyc=%0d got=%h exp=%h", c, {rsp_valid, rsp_id, rsp_err, rsp_data}, {3'b100, exp_d}); else pass_cnt++;
        end
        rsp_ready = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL handshake_regrant got=%b exp=01", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
        total_cnt++; if ({rsp_valid, busy} !== 2'b01) $display("FAIL regrant_exec got=%b exp=01", {rsp_valid, busy}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({rsp_valid, rsp_id, rsp_data} !== {2'b10, exp_d}) $display("FAIL regrant_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_data}, {2'b10, exp_d}); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL single_idle got=%b exp=00", {rsp_valid, busy}); else pass_cnt++;
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int         exp_id;
        logic [8:0] exp_d;
        apply_reset();
        set_req(0, 1'b1, 8'h6B, 8'hAA, 4'h1);
        set_req(1, 1'b1, 8'h6B, 8'hAA, 4'h2);
        rsp_ready = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL b2b_first_grant got=%b exp=01", req_ready); else pass_cnt++;
        exp_id = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL b2b_exec k=%0d got=%b exp=0", k, rsp_valid); else pass_cnt++;
            @(negedge clk);
            exp_d = golden(8'h6B, 8'hAA, (exp_id == 0) ? 1 : 2);
            total_cnt++; if ({rsp_valid, rsp_id} !== {1'b1, 1'(exp_id)}) $display("FAIL b2b_rsp_id k=%0d got=%b exp=%b", k, {rsp_valid, rsp_id}, {1'b1, 1'(exp_id)}); else pass_cnt++;
            total_cnt++; if (rsp_data !== exp_d) $display("FAIL b2b_data k=%0d got=%h exp=%h", k, rsp_data, exp_d); else pass_cnt++;
            total_cnt++; if (req_ready !== ((exp_id == 0) ? 2'b10 : 2'b01)) $display("FAIL b2b_regrant k=%0d got=%b exp=%b", k, req_ready, (exp_id == 0) ? 2'b10 : 2'b01); else pass_cnt++;
            if (k == 3) req_valid = 2'b00;
            exp_id = 1 - exp_id;
        end
        @(negedge clk);
        total_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL b2b_idle got=%b exp=00", {rsp_valid, busy}); else pass_cnt++;
    endtask

    task automatic test_illegal();
        logic [8:0] exp_d;
        exp_d = golden(8'h6B, 8'hAA, 0);
        apply_reset();
        set_req(1, 1'b1, 8'hFF, 8'h01, 4'hC);
        set_req(0, 1'b0, 8'h6B, 8'hAA, 4'h0);
        rsp_ready = 1'b1;
        #1;
        total_cnt++; if (req_ready !== 2'b10) $display("FAIL illegal_grant got=%b exp=10", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        total_cnt++; if (req_ready !== 2'b00) $display("FAIL exec_no_grant got=%b exp=00", req_ready); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b111, 9'h000}) $display("FAIL illegal_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_err, rsp_data}, {3'b111, 9'h000}); else pass_cnt++;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL illegal_next_req0 got=%b exp=01", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        total_cnt++; if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {3'b100, exp_d}) $display("FAIL after_illegal_rsp got=%h exp=%h", {rsp_valid, rsp_id, rsp_err, rsp_data}, {3'b100, exp_d}); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [8:0] exp_d;
        rsp_ready = 1'b1;
        for (int op = 0; op < 12; op++) begin
            exp_d = golden(8'h6B, 8'hAA, op);
            set_req(0, 1'b1, 8'h6B, 8'hAA, 4'(op));
            @(negedge clk);
            req_valid = 2'b00;
            @(negedge clk);
            total_cnt++; if ({rsp_valid, rsp_err} !== 2'b10) $display("FAIL sweep_flags op=%0d got=%b exp=10", op, {rsp_valid, rsp_err}); else pass_cnt++;
            total_cnt++; if (rsp_data !== exp_d) $display("FAIL sweep_data op=%0d got=%h exp=%h", op, rsp_data, exp_d); else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        set_req(1, 1'b1, 8'h12, 8'h34, 4'h3);
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        total_cnt++; if (busy !== 1'b1) $display("FAIL mid_exec_busy got=%b exp=1", busy); else pass_cnt++;
        rst       = 1'b1;
        req_valid = 2'b11;
        #1;
        total_cnt++; if ({rsp_valid, busy, req_ready, rsp_err, rsp_id, rsp_data} !== 15'h0) $display("FAIL mid_reset_outputs got=%h exp=0", {rsp_valid, busy, req_ready, rsp_err, rsp_id, rsp_data}); else pass_cnt++;
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total_cnt++; if ({rsp_valid, busy} !== 2'b00) $display("FAIL mid_no_rsp cyc=%0d got=%b exp=00", c, {rsp_valid, busy}); else pass_cnt++;
        end
        req_valid = 2'b11;
        #1;
        total_cnt++; if (req_ready !== 2'b01) $display("FAIL mid_ptr_zero got=%b exp=01", req_ready); else pass_cnt++;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_random();
        int         ptr_m;
        bit         inflight;
        int         age;
        int         exp_id;
        logic [8:0] exp_d;
        logic       exp_e;
        bit         hs;
        int         w;
        int         op;
        logic [N-1:0] exp_rdy;
        apply_reset();
        ptr_m    = 0;
        inflight = 1'b0;
        age      = 0;
        exp_id   = 0;
        exp_d    = '0;
        exp_e    = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (inflight) age++;
            total_cnt++; if (rsp_valid !== (inflight && age >= 2)) $display("FAIL rand_rsp_valid cyc=%0d got=%b exp=%b", cyc, rsp_valid, (inflight && age >= 2)); else pass_cnt++;
            req_valid = N'($urandom_range(0, 3));
            for (int i = 0; i < N; i++) begin
                req_a[i*W +: W]      = 8'($urandom);
                req_b[i*W +: W]      = 8'($urandom);
                req_op[i*OPW +: OPW] = 4'($urandom_range(0, 15));
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            hs = inflight && (age >= 2) && rsp_ready;
            if (hs) begin
                total_cnt++; if ({rsp_id, rsp_err, rsp_data} !== {1'(exp_id), exp_e, exp_d}) $display("FAIL rand_rsp cyc=%0d got=%h exp=%h", cyc, {rsp_id, rsp_err, rsp_data}, {1'(exp_id), exp_e, exp_d}); else pass_cnt++;
                ptr_m    = (exp_id + 1) % N;
                inflight = 1'b0;
            end
            w       = inflight ? -1 : pick_m(req_valid, ptr_m);
            exp_rdy = '0;
            if (w >= 0) exp_rdy[w] = 1'b1;
            total_cnt++; if (req_ready !== exp_rdy) $display("FAIL rand_grant cyc=%0d got=%b exp=%b", cyc, req_ready, exp_rdy); else pass_cnt++;
            if (w >= 0) begin
                inflight = 1'b1;
                age      = 0;
                exp_id   = w;
                op       = int'(req_op[w*OPW +: OPW]);
                exp_e    = (op >= 12);
                exp_d    = exp_e ? 9'h000 : golden(int'(req_a[w*W +: W]), int'(req_b[w*W +: W]), op);
            end
        end
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_illegal();
        test_sweep();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational alu01 (8-bit a/b, 4-bit op, 9-bit result) between N_REQ requesters.
- Round-robin grant; operands and result are registered.
- Responses return over a valid/ready channel tagged with the requester id.
- Sits between issuing engines and the ALU datapath; the ALU becomes a time-shared resource.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- W, 8, operand width; result width is W+1
- OPW, 4, opcode width
- NUM_OPS, 12, legal opcodes are 0..NUM_OPS-1
- IDW, $clog2(N_REQ) (min 1), response id width

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  one-hot grant/accept, combinational
- req_a  in  N_REQ*W  packed operand a; requester i at [i*W +: W]
- req_b  in  N_REQ*W  packed operand b
- req_op  in  N_REQ*OPW  packed opcode
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  IDW  index of the requester that owns the response
- rsp_data  out  W+1  ALU result (carry/borrow in MSB)
- rsp_err  out  1  opcode was illegal (>= NUM_OPS)
- busy  out  1  high when state != IDLE

Behaviour:
Clock/reset and reset values:
- One clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, busy=0. req_ready is 0 while rst is high.

FSM states: IDLE, EXEC, RESP.
- IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - If a winner exists: req_ready[winner]=1 (one-hot) in that cycle.
  - Latch a/b/op/id into operand registers; go to EXEC.
- EXEC: operand registers drive alu01. At end of cycle, register:
  - rsp_data=alu_out, rsp_id=id, rsp_err=0, rsp_valid=1; go to RESP.
  - If the latched op >= NUM_OPS: rsp_data=0, rsp_err=1 instead.
- RESP: rsp_valid/rsp_id/rsp_data/rsp_err are held stable until rsp_ready=1.
  - On the handshake, rr_ptr=(id+1) mod N_REQ.
  - Same cycle as the handshake, re-arbitrate with the new pointer value. If a winner exists, grant it combinationally, latch its operands and go to EXEC. Otherwise go to IDLE.
  - Back-to-back throughput is therefore 1 result per 2 cycles.
- req_ready is never asserted in EXEC, or in RESP with rsp_ready=0.

Latency:
- Accept edge T -> rsp_valid high from T+2 (first cycle after the EXEC edge).

Request rules:
- Requesters hold valid/operands until ready. The arbiter samples only in the grant cycle.
- Deasserting valid without a grant is tolerated and has no effect.

Fairness:
- A continuously requesting requester waits at most N_REQ-1 grants.

Opcode and width rules:
- Illegal opcodes consume a grant slot and produce a response (err=1). They are never dropped.
- rsp_data width is W+1 exactly as alu01 produces it; no truncation.

Boundary conditions:
- All requesters idle: FSM stays IDLE, no pointer change.
- rr_ptr wraps from N_REQ-1 to 0.
- rst asserted mid-EXEC/RESP: in-flight operation is discarded, no response is issued, all outputs take reset values immediately.

Decomposition:
- Package alu_arb_pkg: state enum (IDLE, EXEC, RESP), NUM_OPS, opcode constants 4'b0000..4'b1011, IDW helper function.
- One sub-module: alu01 instantiated inside, driven from the operand registers.
- Round-robin select is a function in the package, not a separate module.

Test Plan:
- Reset release, req_valid=2'b00 for 5 cycles -> busy=0, rsp_valid=0, req_ready=00 throughout.
- Req0 only, a=8'h6B, b=8'hAA, op=4'h0, accepted cycle T -> rsp_valid at T+2, rsp_id=0, rsp_err=0, rsp_data equals alu01 golden model for those operands. Held while rsp_ready=0 for 3 cycles.
- req_valid=2'b11 held, rsp_ready=1, a=8'h6B, b=8'hAA, ops 1/2 -> grants alternate 0,1,0,1 over 4 responses. New grant in each handshake cycle; one response every 2 cycles.
- Req1 op=4'hC, a=8'hFF, b=8'h01 -> rsp_id=1, rsp_err=1, rsp_data=9'h000. Next grant goes to req0 if pending.
- Sweep op 0..11 on req0 with a=8'h6B, b=8'hAA -> each rsp_data matches the alu01 model, rsp_err=0.
- Assert rst during EXEC of a req1 op -> outputs zero immediately, no response after release, next grant starts from requester 0.
